// File: rtl/e_muldiv_if.sv
// e_muldiv_if: request/result bundle between the EX stage and the multiply/divide unit
interface e_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       md_op;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] data2;
    logic             busy;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;

    modport master (output start, md_op, data1, data2, input busy, hi_out, lo_out);
    modport slave  (input start, md_op, data1, data2, output busy, hi_out, lo_out);
endinterface

// File: rtl/e_muldiv.sv
// e_muldiv: multi-cycle multiply/divide unit owning the HI/LO registers
module e_muldiv #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic        clk,
    input logic        reset,
    e_muldiv_if.slave  md
);
    localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } op_e;

    op_e              op_q;
    op_e              op_in;
    logic [WIDTH-1:0] a_q, b_q, hi, lo;
    logic             busy;
    logic [CW-1:0]    cnt;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] mag_a, mag_b, uq, ur, quo, rem;
    logic             sdiv, neg_a, neg_b, ext_a, ext_b;

    assign op_in     = op_e'(md.md_op);
    assign md.busy   = busy;
    assign md.hi_out = hi;
    assign md.lo_out = lo;

    // Result datapath on the latched operands; signed ops reuse one unsigned core via sign/magnitude
    always_comb begin
        sdiv  = op_q == OP_DIV;
        ext_a = (op_q == OP_MULT) & a_q[WIDTH-1];
        ext_b = (op_q == OP_MULT) & b_q[WIDTH-1];
        prod  = {{WIDTH{ext_a}}, a_q} * {{WIDTH{ext_b}}, b_q};
        neg_a = sdiv & a_q[WIDTH-1];
        neg_b = sdiv & b_q[WIDTH-1];
        mag_a = neg_a ? -a_q : a_q;
        mag_b = neg_b ? -b_q : b_q;
        uq    = mag_b == '0 ? '0 : mag_a / mag_b;
        ur    = mag_b == '0 ? '0 : mag_a % mag_b;
        quo   = (neg_a ^ neg_b) ? -uq : uq;
        rem   = neg_a ? -ur : ur;
    end

    // Accept requests when idle, count down in-flight ops and commit HI/LO on the final edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi   <= '0;
            lo   <= '0;
            busy <= 1'b0;
            cnt  <= '0;
            op_q <= OP_NONE;
            a_q  <= '0;
            b_q  <= '0;
        end else if (busy) begin
            if (cnt == CW'(1)) begin
                busy <= 1'b0;
                cnt  <= '0;
                if (op_q == OP_MULT || op_q == OP_MULTU) begin
                    {hi, lo} <= prod;
                end else if (b_q != '0) begin
                    hi <= rem;
                    lo <= quo;
                end
            end else begin
                cnt <= cnt - CW'(1);
            end
        end else if (md.start) begin
            case (op_in)
                OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                    op_q <= op_in;
                    a_q  <= md.data1;
                    b_q  <= md.data2;
                    busy <= 1'b1;
                    cnt  <= (op_in == OP_MULT || op_in == OP_MULTU) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                end
                OP_MTHI: hi <= md.data1;
                OP_MTLO: lo <= md.data1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_e_muldiv.sv
// tb_e_muldiv: directed scoreboard bench for the multiply/divide unit
module tb_e_muldiv;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int failures = 0;
    logic [63:0] sb_q[$];

    e_muldiv_if #(.WIDTH(32)) bus ();

    e_muldiv #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] d1, input logic [31:0] d2);
        @(negedge clk);
        bus.start = 1'b1;
        bus.md_op = op;
        bus.data1 = d1;
        bus.data2 = d2;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.md_op = 3'd0;
        bus.data1 = $urandom;
        bus.data2 = $urandom;
    endtask

    task automatic wait_done(input string tag, input int n, input int c0);
        int c = c0;
        logic [63:0] e;
        while (bus.busy === 1'b1 && c < 200) begin
            c++;
            @(posedge clk);
            #1;
        end
        chk({tag, "_busy_cycles"}, 64'(c), 64'(n));
        e = sb_q.pop_front();
        chk({tag, "_hilo"}, {bus.hi_out, bus.lo_out}, e);
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [63:0] exp, input int n);
        sb_q.push_back(exp);
        issue(op, d1, d2);
        wait_done(tag, n, 0);
    endtask

    task automatic run_mt(input string tag, input logic [2:0] op, input logic [31:0] d1, input logic [63:0] exp);
        logic [63:0] e;
        sb_q.push_back(exp);
        issue(op, d1, 32'h5555_5555);
        e = sb_q.pop_front();
        chk({tag, "_busy"}, 64'(bus.busy), 64'(0));
        chk({tag, "_hilo"}, {bus.hi_out, bus.lo_out}, e);
    endtask

    initial begin
        logic [31:0] a, b;
        longint sp;
        bus.start = 1'b0;
        bus.md_op = 3'd0;
        bus.data1 = '0;
        bus.data2 = '0;
        #12;
        chk("reset_busy", 64'(bus.busy), 64'(0));
        chk("reset_hilo", {bus.hi_out, bus.lo_out}, 64'(0));
        @(negedge clk);
        reset = 1'b1;

        run_mt("mthi", 3'd5, 32'hDEAD_BEEF, {32'hDEAD_BEEF, 32'h0});
        run_mt("mtlo", 3'd6, 32'h0BAD_F00D, {32'hDEAD_BEEF, 32'h0BAD_F00D});

        issue(3'd4, 32'd100, 32'd7);
        repeat (6) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_busy", 64'(bus.busy), 64'(0));
        chk("async_rst_hilo", {bus.hi_out, bus.lo_out}, 64'(0));
        @(negedge clk);
        reset = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        chk("no_commit_after_rst", {63'(0), bus.busy, bus.hi_out, bus.lo_out} == 128'(0) ? 64'(0) : 64'(1), 64'(0));

        run_op("mult_neg", 3'd1, 32'hFFFF_FFFE, 32'd3, {32'hFFFF_FFFF, 32'hFFFF_FFFA}, 5);
        run_op("multu", 3'd2, 32'hFFFF_FFFE, 32'd3, {32'h0000_0002, 32'hFFFF_FFFA}, 5);
        run_op("div_neg", 3'd3, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 10);
        run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 10);
        run_op("divu", 3'd4, 32'd100, 32'd7, {32'd2, 32'd14}, 10);
        run_op("divu_zero", 3'd4, 32'h1234_5678, 32'd0, {32'd2, 32'd14}, 10);
        run_op("div_zero", 3'd3, 32'h8765_4321, 32'd0, {32'd2, 32'd14}, 10);
        run_op("div_pos_neg", 3'd3, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 10);

        sb_q.push_back({32'd1, 32'd0});
        issue(3'd1, 32'h0001_0000, 32'h0001_0000);
        @(negedge clk);
        bus.start = 1'b1;
        bus.md_op = 3'd6;
        bus.data1 = 32'h0000_1234;
        bus.data2 = 32'h0000_0009;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.md_op = 3'd0;
        chk("ignored_busy", 64'(bus.busy), 64'(1));
        wait_done("mult_ignore", 5, 1);

        for (int i = 0; i < 3; i++) begin
            a = $urandom;
            b = $urandom;
            sp = longint'(signed'(a)) * longint'(signed'(b));
            run_op("mult_rand", 3'd1, a, b, 64'(sp), 5);
            b = $urandom_range(1, 65535);
            run_op("divu_rand", 3'd4, a, b, {a % b, a / b}, 10);
        end

        run_mt("mthi_b2b", 3'd5, 32'hCAFE_0001, {32'hCAFE_0001, {a / b}});
        run_mt("mtlo_b2b", 3'd6, 32'hCAFE_0002, {32'hCAFE_0001, 32'hCAFE_0002});
        run_op("reserved_op", 3'd7, 32'h1111_1111, 32'h2222_2222, {32'hCAFE_0001, 32'hCAFE_0002}, 0);
        run_op("none_op", 3'd0, 32'h3333_3333, 32'h4444_4444, {32'hCAFE_0001, 32'hCAFE_0002}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/e_muldiv.md
Name: E_muldiv

Overview:
- Parametrised multi-cycle multiply/divide unit in the EX stage, alongside the single-cycle ALU.
- Owns the HI/LO registers and executes mult, multu, div, divu, mthi and mtlo.
- Asserts busy while an operation is in flight so the stall unit holds dependent HI/LO instructions in D.

Parameters:
WIDTH, 32, operand and HI/LO register width
MULT_CYCLES, 5, cycles from accepted start to HI/LO commit for mult/multu (>=1)
DIV_CYCLES, 10, cycles from accepted start to HI/LO commit for div/divu (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  single-cycle request, qualified by md_op
md_op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
data1  input  WIDTH  rs operand / dividend / mthi-mtlo source
data2  input  WIDTH  rt operand / divisor
busy  output  1  operation in flight; HI/LO not yet final
hi_out  output  WIDTH  current HI register
lo_out  output  WIDTH  current LO register

Behaviour:
- Reset (reset=0, any time, no clock needed): HI=0, LO=0, busy=0, counter=0, pending op cleared. Any in-flight operation is aborted and never commits.
- Acceptance: start=1 with busy=0 at rising edge t.
  - start while busy=1 is ignored: no latch, counter unaffected.
  - start with md_op 0 or 7 does nothing.
- mult/multu/div/divu:
  - At edge t, latch data1, data2 and op; load counter with MULT_CYCLES or DIV_CYCLES.
  - busy=1 from after edge t through edge t+N-1 (N = latency); counter decrements each edge.
  - At edge t+N, HI/LO take the result and busy falls on that same edge.
  - The first cycle with busy=0 therefore shows the new hi_out/lo_out.
- Results:
  - mult: signed 2*WIDTH product; HI = upper WIDTH bits, LO = lower WIDTH bits.
  - multu: same split, unsigned product.
  - div: LO = signed quotient truncated toward zero; HI = remainder with the dividend's sign.
  - div with dividend = most-negative and divisor = -1: LO = most-negative, HI = 0 (wraps, no trap).
  - divu: LO = unsigned quotient, HI = unsigned remainder.
  - Divisor 0 (div or divu): busy for DIV_CYCLES as normal; HI and LO remain unchanged at commit.
- mthi/mtlo:
  - At edge t, HI (or LO) <= data1; the other register is unchanged; busy stays 0.
  - Accepted only when busy=0, same rule as other ops.
- Result computation is free (combinational on latched operands or iterative). Only the commit edge and busy timing above are architecturally visible.
- hi_out/lo_out are driven straight from registers; no combinational path from inputs.
- Operand changes on data1/data2 after acceptance have no effect.
- Back-to-back: a start at the first edge where busy=0 is accepted. Hence minimum issue spacing is N+1 edges for mult/div and 1 edge for mthi/mtlo.

Test Plan:
1. Reset low mid-div (counter=4): HI=0, LO=0, busy=0 immediately. After release, no commit ever occurs.
2. mult data1=0xFFFFFFFE (-2), data2=3: busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. multu on the same operands then gives HI=0x00000002, LO=0xFFFFFFFA.
3. div data1=0xFFFFFFF9 (-7), data2=2 -> after 10 busy cycles LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). Then div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
4. divu 100/7 -> LO=14, HI=2. Then divu x/0 with prior HI=2, LO=14 -> busy 10 cycles, HI=2 and LO=14 unchanged.
5. mult accepted, second start (mtlo 0x1234) asserted during busy -> ignored. LO ends as the mult result, not 0x1234.
6. mthi 0xDEADBEEF then mtlo 0x0BADF00D on consecutive edges -> busy never asserts. HI/LO read 0xDEADBEEF/0x0BADF00D one edge after each write.
